// File: rtl/top_add.sv
// rtl/top_add.sv - bit-serial four-operand adder, q = (a+b+c+d) mod 2^W
//
// Purpose:
//   Sums four unsigned W-bit operands one bit per clock, LSB first, using
//   three serial full adders: s1 = a+b, s2 = c+d, s = s1+s2. A frame lasts
//   W+1 cycles. The cnt==0 edge loads the operands. The W following edges
//   each produce one sum bit. The last of those edges publishes the
//   completed result on q.
//
// Parameters:
//   W      operand/result width in bits (W >= 2)
//
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-high reset
//   a..d   unsigned operands, sampled only on the LOAD edge (cnt==0)
//   q      registered result, held for a whole frame
//   done   (only with TOP_ADD_DONE_EN) one-cycle pulse following each q update
//
// Optional feature macro: TOP_ADD_DONE_EN

module top_add #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
`ifdef TOP_ADD_DONE_EN
   ,
   output logic         done
`endif
);

   // Counter must represent 0..W inclusive.
   localparam int            CW       = $clog2(W + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(W);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  sa_q, sa_d;
   logic [W-1:0]  sb_q, sb_d;
   logic [W-1:0]  sc_q, sc_d;
   logic [W-1:0]  sd_q, sd_d;
   logic          c1_q, c1_d;
   logic          c2_q, c2_d;
   logic          c3_q, c3_d;
   logic [W-1:0]  res_q, res_d;
   logic [W-1:0]  q_q, q_d;

   logic          is_load;
   logic          is_last;
   logic          s1_bit, s1_cy;
   logic          s2_bit, s2_cy;
   logic          s_bit, s_cy;

   assign is_load = (cnt_q == '0);
   assign is_last = (cnt_q == CNT_LAST);

   // Three serial full adders working on the current LSBs.
   assign s1_bit = sa_q[0] ^ sb_q[0] ^ c1_q;
   assign s1_cy  = (sa_q[0] & sb_q[0]) | (sa_q[0] & c1_q) | (sb_q[0] & c1_q);

   assign s2_bit = sc_q[0] ^ sd_q[0] ^ c2_q;
   assign s2_cy  = (sc_q[0] & sd_q[0]) | (sc_q[0] & c2_q) | (sd_q[0] & c2_q);

   assign s_bit  = s1_bit ^ s2_bit ^ c3_q;
   assign s_cy   = (s1_bit & s2_bit) | (s1_bit & c3_q) | (s2_bit & c3_q);

   always_comb begin
      cnt_d = cnt_q;
      sa_d  = sa_q;
      sb_d  = sb_q;
      sc_d  = sc_q;
      sd_d  = sd_q;
      c1_d  = c1_q;
      c2_d  = c2_q;
      c3_d  = c3_q;
      res_d = res_q;
      q_d   = q_q;

      if (is_last) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

      if (is_load) begin
         sa_d  = a;
         sb_d  = b;
         sc_d  = c;
         sd_d  = d;
         c1_d  = 1'b0;
         c2_d  = 1'b0;
         c3_d  = 1'b0;
         res_d = '0;
      end else begin
         c1_d  = s1_cy;
         c2_d  = s2_cy;
         c3_d  = s_cy;
         sa_d  = {1'b0, sa_q[W-1:1]};
         sb_d  = {1'b0, sb_q[W-1:1]};
         sc_d  = {1'b0, sc_q[W-1:1]};
         sd_d  = {1'b0, sd_q[W-1:1]};
         // Sum bits enter at the MSB so that after W shifts bit 0 is the LSB.
         res_d = {s_bit, res_q[W-1:1]};
         // The final bit is merged directly so q updates on this same edge.
         // Carries out of bit W-1 are simply dropped (modulo 2^W).
         if (is_last) begin
            q_d = {s_bit, res_q[W-1:1]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         sa_q  <= '0;
         sb_q  <= '0;
         sc_q  <= '0;
         sd_q  <= '0;
         c1_q  <= 1'b0;
         c2_q  <= 1'b0;
         c3_q  <= 1'b0;
         res_q <= '0;
         q_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         sa_q  <= sa_d;
         sb_q  <= sb_d;
         sc_q  <= sc_d;
         sd_q  <= sd_d;
         c1_q  <= c1_d;
         c2_q  <= c2_d;
         c3_q  <= c3_d;
         res_q <= res_d;
         q_q   <= q_d;
      end
   end

   assign q = q_q;

`ifdef TOP_ADD_DONE_EN
   logic done_q;

   // High for the cycle right after the edge that updated q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q <= 1'b0;
      end else begin
         done_q <= is_last;
      end
   end

   assign done = done_q;
`endif

endmodule

// File: tb/tb_top_add.sv
// tb/tb_top_add.sv - directed self-checking bench for top_add
module tb_top_add;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic [W-1:0] a, b, c, d;
   logic [W-1:0] q;
`ifdef TOP_ADD_DONE_EN
   logic         done;
`endif

   int total = 0;
   int bad   = 0;
   int ecnt  = 0;

   top_add #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .q   (q)
`ifdef TOP_ADD_DONE_EN
      ,
      .done(done)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Frame position of the most recent edge since reset release (0 = LOAD).
   function automatic int pos();
      return (ecnt - 1) % (W + 1);
   endfunction

   task automatic tick();
      @(posedge clk);
      ecnt++;
      #1;
`ifdef TOP_ADD_DONE_EN
      check("done_pulse", {31'd0, done}, (pos() == W) ? 32'd1 : 32'd0);
`endif
   endtask

   // Advance until the next edge is a LOAD edge; bounded to one frame.
   task automatic wait_load();
      for (int i = 0; i < W + 1; i++) begin
         if (pos() == W) break;
         tick();
      end
      check("align", pos(), W);
   endtask

   task automatic set_ops(input int va, input int vb, input int vc, input int vd);
      a = W'(va);
      b = W'(vb);
      c = W'(vc);
      d = W'(vd);
   endtask

   task automatic check_done_low(input string tag);
`ifdef TOP_ADD_DONE_EN
      check(tag, {31'd0, done}, 32'd0);
`endif
   endtask

   initial begin
      rst = 1'b1;
      set_ops(1, 2, 3, 4);
      #1;
      check("rst_q", q, 0);
      check_done_low("rst_done");
      repeat (3) @(posedge clk);
      #1;
      check("rst_q_hold", q, 0);
      check_done_low("rst_done_hold");

      // Basic sum: first edge after release is LOAD, q valid at edge W+1.
      rst  = 1'b0;
      ecnt = 0;
      for (int e = 1; e <= W; e++) begin
         tick();
         check("pre_q", q, 0);
      end
      tick();
      check("first_q", q, 10);
      for (int i = 0; i < 50; i++) begin
         tick();
         check("stable_q", q, 10);
      end

      // Overflow: 4*255 = 1020 -> 252; old value held until the last edge.
      wait_load();
      set_ops(255, 255, 255, 255);
      repeat (W) tick();
      check("hold_q", q, 10);
      tick();
      check("ovf_all_ff", q, 252);

      wait_load();
      set_ops(255, 1, 0, 0);
      repeat (W + 1) tick();
      check("ovf_wrap0", q, 0);

      // Operand change after the edge with cnt==2 must not affect this frame.
      wait_load();
      set_ops(1, 2, 3, 4);
      repeat (3) tick();
      set_ops(10, 20, 30, 40);
      repeat (W - 2) tick();
      check("mid_cur_frame", q, 10);
      repeat (W + 1) tick();
      check("mid_next_frame", q, 100);

      // Reset mid-frame while cnt==5, with q holding a nonzero value.
      wait_load();
      set_ops(5, 6, 7, 8);
      repeat (5) tick();
      check("pre_rst_q", q, 100);
      rst = 1'b1;
      #1;
      check("async_q", q, 0);
      check_done_low("async_done");
      repeat (2) @(posedge clk);
      #1;
      check("rst2_q", q, 0);
      check_done_low("rst2_done");
      rst  = 1'b0;
      ecnt = 0;
      for (int e = 1; e <= W; e++) begin
         tick();
         check("post_rst_pre_q", q, 0);
      end
      tick();
      check("post_rst_q", q, 26);
      repeat (W + 1) tick();
      check("post_rst_q2", q, 26);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/top_add.md
TOP_ADD -- requirements
Module: top_add

Interface
REQ-001 SHALL have parameter W, default 8, meaning operand and result width in bits (W >= 2).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-004 SHALL have port a, input, W, meaning operand A (unsigned).
REQ-005 SHALL have port b, input, W, meaning operand B (unsigned).
REQ-006 SHALL have port c, input, W, meaning operand C (unsigned).
REQ-007 SHALL have port d, input, W, meaning operand D (unsigned).
REQ-008 SHALL have port q, output, W, meaning registered result (a+b+c+d) mod 2^W.

Function
REQ-009 SHALL compute the sum bit-serially, LSB first, one bit per clock, using three serial full adders: s1=a+b, s2=c+d, s=s1+s2, each with its own 1-bit carry flop.
REQ-010 SHALL use a frame counter cnt cycling 0,1,...,W and wrapping to 0; one frame is W+1 cycles.
REQ-011 SHALL, on the edge with cnt==0 (LOAD), capture a,b,c,d into four W-bit shift registers, clear all three carry flops and clear the result shift register.
REQ-012 SHALL, on each edge with cnt==k (1..W), add the shift-register LSBs with the stored carries, register the new carries, shift operand registers right one bit, and shift the final sum bit into the MSB of the result shift register.
REQ-013 SHALL, on the edge with cnt==W, load q with the completed W-bit result; q holds that value until the next frame's cnt==W edge.
REQ-014 SHALL sample operands only at LOAD; operand changes during cnt 1..W do not affect the current frame.
REQ-015 SHALL discard all carry-outs beyond bit W-1 (result modulo 2^W, no saturation, no overflow flag).
REQ-016 SHALL produce q for operands captured at edge n exactly at edge n+W.
REQ-017 SHALL recompute continuously: every frame reloads the current operands, so constant inputs yield a constant q after the first frame.

Reset
REQ-018 SHALL, while rst is high, immediately force q=0, cnt=0, all carries=0, all shift registers=0.
REQ-019 SHALL treat the first rising edge with rst low as a LOAD edge (cnt==0).
REQ-020 SHALL abandon any partial frame on reset mid-operation; q stays 0 until the first full frame after reset completes.

Configuration
REQ-021 SHALL, when macro TOP_ADD_DONE_EN is defined, add output port done (1 bit, reset 0) that is high for exactly the one cycle following each edge on which q is updated (REQ-013), low otherwise.
REQ-022 SHALL, when TOP_ADD_DONE_EN is undefined, have no done port; all other behaviour identical.

Verification
REQ-023 SHALL verify: rst high 3 cycles, then a=1,b=2,c=3,d=4, rst low -> q=0 for the first W edges, q=10 from edge W+1 (9 for W=8) onward, stable for 50 cycles.
REQ-024 SHALL verify overflow: a=255,b=255,c=255,d=255 -> q=252; a=255,b=1,c=0,d=0 -> q=0.
REQ-025 SHALL verify mid-frame change: a..d=1,2,3,4 loaded, change to 10,20,30,40 at cnt==3 -> q=10 this frame, q=100 after the following frame.
REQ-026 SHALL verify reset mid-frame: assert rst at cnt==5 -> q=0 asynchronously; after release, q=0 until W+1 edges, then correct sum.
REQ-027 SHALL verify with TOP_ADD_DONE_EN defined: done pulses one cycle every W+1 cycles, coincident with each new q value; never high during reset.
